// File: rtl/norm_pkg.sv
// Shared types for the iterative normalizer: FSM state encoding and the F mode
// encoding, which matches the barrel shifter so the two blocks can be chained.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } norm_state_t;

  localparam logic [1:0] NORM_LEFT   = 2'd0;
  localparam logic [1:0] NORM_RIGHT  = 2'd1;
  localparam logic [1:0] NORM_PASS   = 2'd2;
  localparam logic [1:0] NORM_SIGNED = 2'd3;

endpackage

// File: rtl/norm_stop_detect.sv
// Stop flag for the normalizer's working register, selected by mode.
// NORM_SIGNED_EN enables signed left-normalize for mode 3; otherwise mode 3 acts as mode 0.
module norm_stop_detect
  import norm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] work,
  input  logic [1:0]   mode,
  output logic         stop
);

  always_comb begin
    stop = work[W-1];
    case (mode)
      NORM_RIGHT:  stop = work[0];
      NORM_PASS:   stop = 1'b1;
`ifdef NORM_SIGNED_EN
      // Stop once the top two bits differ: no redundant sign bits remain.
      NORM_SIGNED: stop = work[W-1] ^ work[W-2];
`endif
      default:     stop = work[W-1];
    endcase
  end

endmodule

// File: rtl/seq_normalizer.sv
// Iterative normalizer, one bit per clock: returns normalized Y and the shift count Sh.
// Mode 3 signed normalize is built only with NORM_SIGNED_EN (see norm_stop_detect).
module seq_normalizer
  import norm_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = 2 ** N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [1:0]   F,
  output logic [W-1:0] Y,
  output logic [N-1:0] Sh,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  norm_state_t  state, state_next;
  logic [W-1:0] work, work_next;
  logic [N-1:0] count, count_next;
  logic [1:0]   mode, mode_next;
  logic [W-1:0] y_next;
  logic [N-1:0] sh_next;
  logic         zero_next;
  logic         stop;

  norm_stop_detect #(.W(W)) u_stop (
    .work (work),
    .mode (mode),
    .stop (stop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      count <= '0;
      mode  <= NORM_LEFT;
      Y     <= '0;
      Sh    <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_next;
      work  <= work_next;
      count <= count_next;
      mode  <= mode_next;
      Y     <= y_next;
      Sh    <= sh_next;
      zero  <= zero_next;
    end
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    count_next = count;
    mode_next  = mode;
    y_next     = Y;
    sh_next    = Sh;
    zero_next  = zero;
    case (state)
      IDLE: begin
        if (start) begin
          work_next  = A;
          mode_next  = F;
          count_next = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (work == '0) begin
          y_next     = '0;
          sh_next    = '0;
          zero_next  = 1'b1;
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (stop) begin
          y_next     = work;
          sh_next    = count;
          zero_next  = 1'b0;
          state_next = DONE;
        end else begin
          // Non-zero operand always stops within W-1 shifts, so count cannot wrap.
          work_next  = (mode == NORM_RIGHT) ? (work >> 1) : (work << 1);
          count_next = count + N'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == LOAD) || (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer: directed cases, handshake corner cases,
// and randomized operands checked against a counting model and an inverse shifter.
module tb_seq_normalizer;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [1:0]   f = '0;
  logic [W-1:0] y;
  logic [N-1:0] sh;
  logic         zero;
  logic         busy;
  logic         done;

  int tests = 0;
  int failed = 0;

  seq_normalizer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (a),
    .F     (f),
    .Y     (y),
    .Sh    (sh),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference: count leading/trailing zeros or redundant sign bits directly.
  function automatic void ref_norm(input logic [7:0] av, input logic [1:0] fv,
                                   output logic [7:0] ey, output int ek, output logic ez);
    int run;
    ey = av; ek = 0; ez = 1'b0;
    if (av == 8'h00) begin
      ey = 8'h00; ez = 1'b1;
      return;
    end
`ifndef NORM_SIGNED_EN
    if (fv == 2'd3) fv = 2'd0;
`endif
    case (fv)
      2'd0: begin
        for (int i = 0; i < 8; i++) if (av[i]) ek = 7 - i;
        ey = av << ek;
      end
      2'd1: begin
        for (int i = 7; i >= 0; i--) if (av[i]) ek = i;
        ey = av >> ek;
      end
      2'd2: ey = av;
      default: begin
        run = 0;
        for (int i = 7; i >= 0; i--) begin
          if (av[i] != av[7]) break;
          run++;
        end
        ek = run - 1;
        ey = av << ek;
      end
    endcase
  endfunction

  // The barrel shifter the normalizer inverts.
  function automatic logic [7:0] barrel(input logic [7:0] yv, input logic [1:0] fv, input int s);
    case (fv)
      2'd0: return yv >> s;
      2'd1: return yv << s;
      2'd2: return yv;
`ifdef NORM_SIGNED_EN
      default: return 8'($signed(yv) >>> s);
`else
      default: return yv >> s;
`endif
    endcase
  endfunction

  // Launches one operation and observes done/busy; lat = -1 if done never came.
  task automatic run_op(input logic [7:0] av, input logic [1:0] fv, input bit hold,
                        output int lat, output int busy_cyc, output int done_cnt);
    @(negedge clk);
    a = av; f = fv; start = 1'b1;
    @(posedge clk);
    lat = -1; busy_cyc = 0; done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin
          a = 8'($urandom); f = 2'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        start = 1'b0;
        if (lat < 0) lat = c;
      end
      if (lat >= 0 && c >= lat + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (y !== 8'h00 || sh !== 3'd0 || zero !== 1'b0) begin
      failed++; $display("FAIL reset_outputs: Y=%h Sh=%0d zero=%b, required 00/0/0", y, sh, zero);
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failed++; $display("FAIL reset_handshake: busy=%b done=%b, required 0/0", busy, done);
    end
    reset = 1'b0;
  endtask

  typedef struct { logic [7:0] av; logic [1:0] fv; logic [7:0] ey; int ek; } dcase_t;

  task automatic test_directed();
    dcase_t cases[$];
    int lat, bc, dc;
    cases.push_back('{8'h01, 2'd0, 8'h80, 7});
    cases.push_back('{8'h28, 2'd1, 8'h05, 3});
    cases.push_back('{8'h28, 2'd0, 8'hA0, 2});
    cases.push_back('{8'h5A, 2'd2, 8'h5A, 0});
`ifdef NORM_SIGNED_EN
    cases.push_back('{8'hF3, 2'd3, 8'h98, 3});
    cases.push_back('{8'hFF, 2'd3, 8'h80, 7});
`else
    cases.push_back('{8'hF3, 2'd3, 8'hF3, 0});
`endif
    foreach (cases[i]) begin
      run_op(cases[i].av, cases[i].fv, 1'b0, lat, bc, dc);
      tests++;
      if (y !== cases[i].ey || int'(sh) != cases[i].ek || zero !== 1'b0) begin
        failed++;
        $display("FAIL directed_result A=%h F=%0d: Y=%h Sh=%0d zero=%b, required %h/%0d/0",
                 cases[i].av, cases[i].fv, y, sh, zero, cases[i].ey, cases[i].ek);
      end
      tests++;
      if (lat != cases[i].ek + 3 || bc != cases[i].ek + 2 || dc != 1) begin
        failed++;
        $display("FAIL directed_timing A=%h F=%0d: latency=%0d busy=%0d dones=%0d, required %0d/%0d/1",
                 cases[i].av, cases[i].fv, lat, bc, dc, cases[i].ek + 3, cases[i].ek + 2);
      end
    end
  endtask

  task automatic test_zero();
    int lat, bc, dc;
    for (int m = 0; m < 4; m++) begin
      run_op(8'h00, 2'(m), 1'b0, lat, bc, dc);
      tests++;
      if (y !== 8'h00 || sh !== 3'd0 || zero !== 1'b1 || lat != 2 || bc != 1 || dc != 1) begin
        failed++;
        $display("FAIL zero_input F=%0d: Y=%h Sh=%0d zero=%b latency=%0d busy=%0d dones=%0d, required 00/0/1/2/1/1",
                 m, y, sh, zero, lat, bc, dc);
      end
    end
  endtask

  task automatic test_start_held();
    int lat, bc, dc;
    run_op(8'h01, 2'd0, 1'b1, lat, bc, dc);
    tests++;
    if (y !== 8'h80 || sh !== 3'd7 || lat != 10 || dc != 1) begin
      failed++;
      $display("FAIL start_held: Y=%h Sh=%0d latency=%0d dones=%0d, required 80/7/10/1", y, sh, lat, dc);
    end
  endtask

  task automatic test_reset_mid();
    int dc = 0;
    @(negedge clk);
    a = 8'h01; f = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (y !== 8'h00 || sh !== 3'd0 || zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid: Y=%h Sh=%0d zero=%b busy=%b done=%b, required all 0", y, sh, zero, busy, done);
    end
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dc++;
    end
    tests++;
    if (dc != 0) begin
      failed++; $display("FAIL reset_mid_no_done: dones=%0d, required 0", dc);
    end
  endtask

  task automatic test_random();
    int lat, bc, dc, ek;
    logic [7:0] av, ey;
    logic [1:0] fv;
    logic ez;
    for (int i = 0; i < 200; i++) begin
      av = 8'($urandom_range(1, 255));
      fv = 2'($urandom_range(0, 3));
      ref_norm(av, fv, ey, ek, ez);
      run_op(av, fv, 1'b0, lat, bc, dc);
      tests++;
      if (y !== ey || int'(sh) != ek || zero !== ez || lat != ek + 3 || dc != 1) begin
        failed++;
        $display("FAIL random A=%h F=%0d: Y=%h Sh=%0d zero=%b latency=%0d dones=%0d, required %h/%0d/%b/%0d/1",
                 av, fv, y, sh, zero, lat, dc, ey, ek, ez, ek + 3);
      end
      tests++;
      if (barrel(y, fv, int'(sh)) !== av) begin
        failed++;
        $display("FAIL inverse A=%h F=%0d: shifter gives %h, required %h",
                 av, fv, barrel(y, fv, int'(sh)), av);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
